// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU operation codes and the main FSM state type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1000;

    typedef enum logic [1:0] {
        ACLS_ADD   = 2'b00,
        ACLS_SUB   = 2'b01,
        ACLS_FUNCT = 2'b10
    } alu_class_t;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RALU   = 4'd7,
        S_RWB    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

endpackage

// File: rtl/mips_alu_decode.sv
// ALU operation decode from an operation class and the R-type funct field.
// funct_legal reports funct support regardless of class so DECODE can screen R-types.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  alu_class_t alu_class,
    output logic [3:0] alu_ctrl,
    output logic       funct_legal
);

    logic [3:0] funct_op;

    always_comb begin
        funct_op    = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  funct_op = ALU_ADD;
            FN_SUB:  funct_op = ALU_SUB;
            FN_AND:  funct_op = ALU_AND;
            FN_OR:   funct_op = ALU_OR;
            FN_SLT:  funct_op = ALU_SLT;
            FN_NOR:  funct_op = ALU_NOR;
            default: funct_legal = 1'b0;
        endcase

        alu_ctrl = ALU_ADD;
        case (alu_class)
            ACLS_SUB:   alu_ctrl = ALU_SUB;
            ACLS_FUNCT: alu_ctrl = funct_op;
            default:    alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: Moore FSM driving datapath selects and strobes,
// plus a retired-instruction counter.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             Zero,
    output logic [3:0]       ALUctrlop,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic             pc_en,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state, state_next;
    alu_class_t alu_class;
    logic       funct_legal;
    logic       pc_write, branch, retire;

    mips_alu_decode u_alu_decode (
        .funct       (funct),
        .alu_class   (alu_class),
        .alu_ctrl    (ALUctrlop),
        .funct_legal (funct_legal)
    );

    assign pc_en = pc_write | (branch & Zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_START;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

    always_comb begin
        state_next = S_FETCH;
        alu_class  = ACLS_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_START: state_next = S_FETCH;
            S_FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                pc_write   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is dispatched
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal) state_next = S_RALU;
                        else             illegal    = 1'b1;
                    end
                    OP_ADDI: state_next = S_ADDIEX;
                    OP_BEQ:  state_next = S_BRANCH;
                    OP_J:    state_next = S_JUMP;
                    default: illegal    = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = 1'b1;
            end
            S_RALU: begin
                ALUSrcA    = 1'b1;
                alu_class  = ACLS_FUNCT;
                state_next = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                alu_class = ACLS_SUB;
                branch    = 1'b1;
                PCSource  = 2'b01;
                retire    = 1'b1;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle output vectors checked against
// hand-written expectations for each state of every instruction class.
module tb_mips_mc_control;
    import mips_ctrl_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode, funct;
    logic             Zero;
    logic [3:0]       ALUctrlop;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB, PCSource;
    logic             pc_en, IorD, MemRead, MemWrite, IRWrite;
    logic             RegDst, MemtoReg, RegWrite, illegal;
    logic [CNT_W-1:0] instr_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_cnt  = '0;

    mips_mc_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
        .ALUctrlop(ALUctrlop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {ALUctrlop, ALUSrcA, ALUSrcB, PCSource, pc_en, IorD, MemRead,
                   MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, illegal};

    function automatic logic [17:0] mk(input logic [3:0] alu, input logic srca,
                                       input logic [1:0] srcb, input logic [1:0] pcs,
                                       input logic pcen, input logic iord, input logic mr,
                                       input logic mw, input logic irw, input logic rdst,
                                       input logic m2r, input logic rw, input logic ill);
        return {alu, srca, srcb, pcs, pcen, iord, mr, mw, irw, rdst, m2r, rw, ill};
    endfunction

    //                        alu     A  B      PCS    en iD mR mW IR RD M2 RW il
    wire [17:0] V_START  = mk(4'b0010,0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wire [17:0] V_FETCH  = mk(4'b0010,0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    wire [17:0] V_DECODE = mk(4'b0010,0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wire [17:0] V_DECILL = mk(4'b0010,0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    wire [17:0] V_MEMADR = mk(4'b0010,1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wire [17:0] V_MEMRD  = mk(4'b0010,0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    wire [17:0] V_MEMWB  = mk(4'b0010,0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    wire [17:0] V_MEMWR  = mk(4'b0010,0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    wire [17:0] V_RWB    = mk(4'b0010,0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    wire [17:0] V_ADDIEX = mk(4'b0010,1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wire [17:0] V_ADDIWB = mk(4'b0010,0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    wire [17:0] V_JUMP   = mk(4'b0010,0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic cyc(input string tag, input logic [17:0] want);
        check(tag, 32'(outs), 32'(want));
        @(negedge clk);
    endtask

    task automatic check_cnt(input string tag);
        check(tag, 32'(instr_count), 32'(exp_cnt));
    endtask

    logic [5:0] rfn [6] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR};
    logic [3:0] rop [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1000};

    initial begin
        reset = 1'b1; opcode = OP_LW; funct = 6'd0; Zero = 1'b0;
        @(negedge clk);
        check("rst_outs", 32'(outs), 32'(V_START));
        check_cnt("rst_cnt");
        @(negedge clk);
        reset = 1'b0;
        cyc("start", V_START);

        // lw: 5 cycles
        opcode = OP_LW;
        cyc("lw_fetch", V_FETCH); cyc("lw_dec", V_DECODE); cyc("lw_adr", V_MEMADR);
        cyc("lw_rd", V_MEMRD);    cyc("lw_wb", V_MEMWB);
        exp_cnt++; check_cnt("lw_cnt");

        // reset in the middle of MEMRD
        cyc("lw2_fetch", V_FETCH); cyc("lw2_dec", V_DECODE); cyc("lw2_adr", V_MEMADR);
        check("lw2_rd", 32'(outs), 32'(V_MEMRD));
        reset = 1'b1;
        #1;
        check("midrst_outs", 32'(outs), 32'(V_START));
        exp_cnt = '0; check_cnt("midrst_cnt");
        @(negedge clk);
        reset = 1'b0;
        cyc("rel_start", V_START);
        check("rel_fetch", 32'(outs), 32'(V_FETCH));
        check_cnt("rel_cnt");

        // R-type, every funct
        opcode = OP_RTYPE;
        for (int i = 0; i < 6; i++) begin
            funct = rfn[i];
            cyc("r_fetch", V_FETCH); cyc("r_dec", V_DECODE);
            cyc("r_alu", mk(rop[i], 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            cyc("r_wb", V_RWB);
            exp_cnt++; check_cnt("r_cnt");
        end

        // addi and sw: 4 cycles each
        opcode = OP_ADDI;
        cyc("addi_fetch", V_FETCH); cyc("addi_dec", V_DECODE);
        cyc("addi_ex", V_ADDIEX);   cyc("addi_wb", V_ADDIWB);
        exp_cnt++; check_cnt("addi_cnt");
        opcode = OP_SW;
        cyc("sw_fetch", V_FETCH); cyc("sw_dec", V_DECODE);
        cyc("sw_adr", V_MEMADR);  cyc("sw_wr", V_MEMWR);
        exp_cnt++; check_cnt("sw_cnt");

        // beq taken / not taken; Zero high outside BRANCH must not matter
        opcode = OP_BEQ;
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            cyc("beq_fetch", V_FETCH); cyc("beq_dec", V_DECODE);
            cyc("beq_br", mk(4'b0110, 1, 2'b00, 2'b01, z[0], 0, 0, 0, 0, 0, 0, 0, 0));
            exp_cnt++; check_cnt("beq_cnt");
        end
        Zero = 1'b0;

        // illegal opcode, then illegal funct: 2 cycles, no retire
        opcode = 6'b111111;
        cyc("ill_op_fetch", V_FETCH); cyc("ill_op_dec", V_DECILL);
        check_cnt("ill_op_cnt");
        opcode = OP_RTYPE; funct = 6'b000000;
        cyc("ill_fn_fetch", V_FETCH); cyc("ill_fn_dec", V_DECILL);
        check("ill_fn_back", 32'(outs), 32'(V_FETCH));
        check_cnt("ill_fn_cnt");

        // 16 jumps: counter wraps through 15 -> 0
        opcode = OP_J;
        for (int k = 0; k < 16; k++) begin
            cyc("j_fetch", V_FETCH); cyc("j_dec", V_DECODE); cyc("j_jump", V_JUMP);
            exp_cnt++; check_cnt("j_cnt");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
